// File: rtl/regfile_sb.sv
// Parametrised integer register file with per-register busy scoreboard, flush and live busy count.
// Define REGFILE_BYPASS_EN to forward a same-cycle writeback onto matching read ports.
module regfile_sb #(
   parameter int unsigned  XLEN  = 32,
   parameter int unsigned  NREGS = 32,
   parameter int unsigned  NRD   = 2,
   localparam int unsigned AW    = $clog2(NREGS)
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [NRD*AW-1:0] raddr_i,
   output logic [NRD*XLEN-1:0] rdata_o,
   output logic [NRD-1:0]    rbusy_o,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [XLEN-1:0]   wdata_i,
   input  logic              issue_i,
   input  logic [AW-1:0]     issue_rd_i,
   input  logic              flush_i,
   output logic [AW:0]       busy_cnt_o,
   output logic              any_busy_o
);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [NREGS-1:0] busy_q, busy_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             any_q, any_d;
   logic             wr_en, iss_en;
   logic             cnt_inc, cnt_dec;

   // x0 is never written nor marked busy; flush squashes the issue
   assign wr_en  = we_i && (waddr_i != '0);
   assign iss_en = issue_i && (issue_rd_i != '0) && !flush_i;

   // A same-register issue+write leaves the bit set, so it never decrements
   assign cnt_inc = iss_en && !busy_q[issue_rd_i];
   assign cnt_dec = wr_en && busy_q[waddr_i] && !(iss_en && (issue_rd_i == waddr_i));

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      if (wr_en)  busy_d[waddr_i]    = 1'b0;
      if (iss_en) busy_d[issue_rd_i] = 1'b1;
      if (flush_i) begin
         busy_d = '0;
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_q + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
      end
      any_d = (cnt_d != '0);
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         busy_q <= '0;
         cnt_q  <= '0;
         any_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         any_q  <= any_d;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int r = 0; r < int'(NREGS); r++) regs_q[r] <= '0;
      end else if (wr_en) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   // Combinational read ports
   always_comb begin
      logic [AW-1:0] ra;
      ra      = '0;
      rdata_o = '0;
      rbusy_o = '0;
      for (int i = 0; i < int'(NRD); i++) begin
         ra = raddr_i[i*AW +: AW];
         rdata_o[i*XLEN +: XLEN] = regs_q[ra];
         rbusy_o[i]              = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
         if (reset_i && wr_en && (waddr_i == ra)) begin
            rdata_o[i*XLEN +: XLEN] = wdata_i;
            rbusy_o[i]              = issue_i && (issue_rd_i == ra);
         end
`endif
      end
   end

   assign busy_cnt_o = cnt_q;
   assign any_busy_o = any_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: expected read/count values are queued at drive time and checked once settled.
module tb_regfile_sb;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREGS = 32;
   localparam int unsigned NRD   = 2;
   localparam int unsigned AW    = 5;

   logic                clk;
   logic                reset_i;
   logic [NRD*AW-1:0]   raddr_i;
   logic [NRD*XLEN-1:0] rdata_o;
   logic [NRD-1:0]      rbusy_o;
   logic                we_i;
   logic [AW-1:0]       waddr_i;
   logic [XLEN-1:0]     wdata_i;
   logic                issue_i;
   logic [AW-1:0]       issue_rd_i;
   logic                flush_i;
   logic [AW:0]         busy_cnt_o;
   logic                any_busy_o;

   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
      .clk_i      (clk),
      .reset_i    (reset_i),
      .raddr_i    (raddr_i),
      .rdata_o    (rdata_o),
      .rbusy_o    (rbusy_o),
      .we_i       (we_i),
      .waddr_i    (waddr_i),
      .wdata_i    (wdata_i),
      .issue_i    (issue_i),
      .issue_rd_i (issue_rd_i),
      .flush_i    (flush_i),
      .busy_cnt_o (busy_cnt_o),
      .any_busy_o (any_busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [XLEN-1:0] d0;
      logic [XLEN-1:0] d1;
      logic [1:0]      b;
      logic [AW:0]     cnt;
      logic            any;
   } exp_t;

   exp_t            sb_q[$];
   logic [XLEN-1:0] m_regs [NREGS];
   logic            m_busy [NREGS];
   int              n_tests = 0;
   int              n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_clear();
      for (int r = 0; r < int'(NREGS); r++) begin
         m_regs[r] = '0;
         m_busy[r] = 1'b0;
      end
   endfunction

   function automatic int model_cnt();
      int c = 0;
      for (int r = 0; r < int'(NREGS); r++) if (m_busy[r]) c++;
      return c;
   endfunction

   function automatic void exp_rd(input logic [AW-1:0] a, output logic [XLEN-1:0] d, output logic b);
      d = m_regs[a];
      b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (reset_i && we_i && (waddr_i != '0) && (waddr_i == a)) begin
         d = wdata_i;
         b = issue_i && (issue_rd_i == a);
      end
`endif
   endfunction

   // Drive one cycle, queue its expected outputs, check them, then advance the model across the edge
   task automatic step(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                       input logic iss, input logic [AW-1:0] ird, input logic fl,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1, input string tag);
      exp_t e;
      exp_t g;
      logic b0, b1;
      we_i = we; waddr_i = wa; wdata_i = wd;
      issue_i = iss; issue_rd_i = ird; flush_i = fl;
      raddr_i = {r1, r0};
      exp_rd(r0, e.d0, b0);
      exp_rd(r1, e.d1, b1);
      e.b   = {b1, b0};
      e.cnt = (AW+1)'(model_cnt());
      e.any = (model_cnt() != 0);
      sb_q.push_back(e);
      #1;
      g = sb_q.pop_front();
      check({tag, ".rd0"},  64'(rdata_o[XLEN-1:0]),    64'(g.d0));
      check({tag, ".rd1"},  64'(rdata_o[2*XLEN-1:XLEN]), 64'(g.d1));
      check({tag, ".rbusy"}, 64'(rbusy_o),             64'(g.b));
      check({tag, ".cnt"},  64'(busy_cnt_o),           64'(g.cnt));
      check({tag, ".any"},  64'(any_busy_o),           64'(g.any));
      @(posedge clk);
      if (reset_i) begin
         if (we && wa != '0) begin
            m_regs[wa] = wd;
            m_busy[wa] = 1'b0;
         end
         if (iss && ird != '0 && !fl) m_busy[ird] = 1'b1;
         if (fl) for (int r = 0; r < int'(NREGS); r++) m_busy[r] = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic idle_rd(input logic [AW-1:0] r0, input logic [AW-1:0] r1, input string tag);
      step(1'b0, '0, '0, 1'b0, '0, 1'b0, r0, r1, tag);
   endtask

   initial begin
      reset_i = 1'b0;
      we_i = 1'b0; waddr_i = '0; wdata_i = '0;
      issue_i = 1'b0; issue_rd_i = '0; flush_i = 1'b0; raddr_i = '0;
      model_clear();
      @(negedge clk);

      // Reset held: random traffic is lost and all outputs stay zero
      for (int k = 0; k < 3; k++)
         step(1'b1, AW'($urandom_range(1, 31)), $urandom, 1'b1, AW'($urandom_range(1, 31)), 1'b0,
              AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)), "rst_hold");
      reset_i = 1'b1;
      idle_rd(5, 7, "rst_rel");

      step(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 1'b0, 5, 0, "wr_x5");
      idle_rd(5, 0, "rd_x5");

      // x0 protection
      step(1'b1, 0, 32'hFFFFFFFF, 1'b1, 0, 1'b0, 0, 0, "x0_wr");
      idle_rd(0, 0, "x0_rd");

      // Scoreboard
      step(1'b0, 0, 0, 1'b1, 3, 1'b0, 3, 7, "iss3");
      step(1'b0, 0, 0, 1'b1, 7, 1'b0, 3, 7, "iss7");
      step(1'b0, 0, 0, 1'b1, 9, 1'b0, 3, 7, "iss9");
      idle_rd(9, 7, "cnt3");
      step(1'b1, 7, 32'h0000_0777, 1'b0, 0, 1'b0, 7, 9, "wr7");
      idle_rd(7, 9, "cnt2");
      step(1'b1, 3, 32'h0000_0333, 1'b1, 3, 1'b0, 3, 7, "iss_wr3");
      idle_rd(3, 7, "x3_busy");

      // Flush with four busy and a squashed issue
      step(1'b0, 0, 0, 1'b1, 13, 1'b0, 13, 14, "iss13");
      step(1'b0, 0, 0, 1'b1, 14, 1'b0, 13, 14, "iss14");
      step(1'b0, 0, 0, 1'b1, 10, 1'b1, 10, 3, "flush");
      idle_rd(10, 3, "post_flush");

      // Same-cycle write on a read port
      step(1'b1, 12, 32'h0000_1234, 1'b0, 0, 1'b0, 0, 12, "byp");
      idle_rd(0, 12, "byp_next");
      step(1'b1, 12, 32'h0000_5678, 1'b1, 12, 1'b0, 12, 12, "byp_iss");
      idle_rd(12, 12, "byp_iss_next");

      // Random traffic against the model
      for (int k = 0; k < 80; k++)
         step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
              1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), ($urandom_range(0, 11) == 0),
              AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)), "rand");

      // Reset mid-operation
      step(1'b0, 0, 0, 1'b0, 0, 1'b1, 0, 0, "pre_flush");
      step(1'b1, 4, 32'hA5A5A5A5, 1'b1, 1, 1'b0, 4, 1, "mid_wr4");
      step(1'b0, 0, 0, 1'b1, 2, 1'b0, 4, 1, "mid_i2");
      step(1'b0, 0, 0, 1'b1, 6, 1'b0, 4, 2, "mid_i6");
      step(1'b0, 0, 0, 1'b1, 8, 1'b0, 4, 6, "mid_i8");
      step(1'b0, 0, 0, 1'b1, 11, 1'b0, 4, 8, "mid_i11");
      idle_rd(4, 11, "mid_busy5");
      raddr_i = {5'(11), 5'(4)};
      #2;
      reset_i = 1'b0;
      #1;
      check("arst.rd0",  64'(rdata_o[XLEN-1:0]),      64'h0);
      check("arst.rd1",  64'(rdata_o[2*XLEN-1:XLEN]), 64'h0);
      check("arst.rbusy", 64'(rbusy_o),               64'h0);
      check("arst.cnt",  64'(busy_cnt_o),             64'h0);
      check("arst.any",  64'(any_busy_o),             64'h0);
      model_clear();
      #1;
      reset_i = 1'b1;
      @(negedge clk);
      idle_rd(4, 11, "post_arst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
